// File: rtl/alu_seq_if.sv
// Request/result bus for alu_seq: operand handshake in, registered result and flags out.
interface alu_seq_if #(
    parameter int unsigned BUS_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] a;
    logic [BUS_WIDTH-1:0] b;
    logic [3:0]           opcode;
    logic                 out_valid;
    logic                 out_ready;
    logic [BUS_WIDTH-1:0] y;
    logic                 carry_out;
    logic                 borrow;
    logic                 zero;
    logic                 parity;
    logic                 invalid_op;
    logic                 carry_flag;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, y, carry_out, borrow, zero, parity, invalid_op, carry_flag
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, y, carry_out, borrow, zero, parity, invalid_op, carry_flag
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with IDLE/EXEC/DONE handshake, iterative rotates and a persistent carry flag.
// Optional iterative shift-add multiplier on opcode 12 when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int unsigned W     = BUS_WIDTH;
    localparam int unsigned WX    = BUS_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(BUS_WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4;
    localparam logic [3:0] OP_DEC = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_OR  = 4'd10;
    localparam logic [3:0] OP_XOR = 4'd11;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd12;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       y_q, y_d;
    logic               co_q, co_d, br_q, br_d, zero_q, zero_d, par_q, par_d;
    logic               inv_q, inv_d, cf_q, cf_d;
    logic               in_ready_q, out_valid_q;
`ifdef ALU_SEQ_MUL_EN
    logic [2*W-1:0]     prod_q, prod_d, mcand_q, mcand_d, prod_nx;
`endif

    logic [W:0]         add_ext, sub_ext, inc_ext, dec_ext;
    logic [W-1:0]       rol1, ror1, res;
    logic               fin, res_co, res_br, res_inv, cf_load;

    // Single-cycle arithmetic; a_q doubles as the rotate working register
    assign add_ext = {1'b0, a_q} + {1'b0, b_q} + WX'((op_q == OP_ADC) & cf_q);
    assign sub_ext = {1'b0, a_q} - {1'b0, b_q};
    assign inc_ext = {1'b0, a_q} + WX'(1);
    assign dec_ext = {1'b0, a_q} - WX'(1);
    assign rol1    = {a_q[W-2:0], a_q[W-1]};
    assign ror1    = {a_q[0], a_q[W-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        co_d    = co_q;
        br_d    = br_q;
        zero_d  = zero_q;
        par_d   = par_q;
        inv_d   = inv_q;
        cf_d    = cf_q;
        res     = '0;
        res_co  = 1'b0;
        res_br  = 1'b0;
        res_inv = 1'b0;
        cf_load = 1'b0;
        fin     = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        prod_d  = prod_q;
        mcand_d = mcand_q;
        prod_nx = prod_q + (b_q[0] ? mcand_q : '0);
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.opcode;
                    // Rotates count n = b mod W steps; multiply counts W partial products
                    cnt_d   = (bus.opcode == OP_ROL || bus.opcode == OP_ROR)
                              ? CNT_W'(32'(bus.b) % W) : CNT_W'(W);
`ifdef ALU_SEQ_MUL_EN
                    prod_d  = '0;
                    mcand_d = {{W{1'b0}}, bus.a};
`endif
                    state_d = EXEC;
                end
            end

            EXEC: begin
                case (op_q)
                    OP_ADD, OP_ADC: begin
                        fin = 1'b1; res = add_ext[W-1:0]; res_co = add_ext[W]; cf_load = 1'b1;
                    end
                    OP_SUB: begin
                        fin = 1'b1; res = sub_ext[W-1:0]; res_br = sub_ext[W]; cf_load = 1'b1;
                    end
                    OP_INC: begin
                        fin = 1'b1; res = inc_ext[W-1:0]; res_co = inc_ext[W]; cf_load = 1'b1;
                    end
                    OP_DEC: begin
                        fin = 1'b1; res = dec_ext[W-1:0]; res_br = dec_ext[W]; cf_load = 1'b1;
                    end
                    OP_AND: begin fin = 1'b1; res = a_q & b_q; end
                    OP_NOT: begin fin = 1'b1; res = ~a_q;      end
                    OP_OR:  begin fin = 1'b1; res = a_q | b_q; end
                    OP_XOR: begin fin = 1'b1; res = a_q ^ b_q; end
                    OP_ROL, OP_ROR: begin
                        // Last step finishes straight from the rotator; n=0 returns a unchanged
                        if (cnt_q <= CNT_W'(1)) begin
                            fin = 1'b1;
                            if (cnt_q == '0)        res = a_q;
                            else if (op_q == OP_ROL) res = rol1;
                            else                     res = ror1;
                        end else begin
                            a_d   = (op_q == OP_ROL) ? rol1 : ror1;
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
`ifdef ALU_SEQ_MUL_EN
                    OP_MUL: begin
                        prod_d  = prod_nx;
                        mcand_d = mcand_q << 1;
                        b_d     = b_q >> 1;
                        cnt_d   = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            fin    = 1'b1;
                            res    = prod_nx[W-1:0];
                            res_co = |prod_nx[2*W-1:W];
                        end
                    end
`endif
                    default: begin fin = 1'b1; res_inv = 1'b1; end
                endcase
            end

            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d = DONE;
            y_d     = res;
            co_d    = res_co;
            br_d    = res_br;
            inv_d   = res_inv;
            zero_d  = (res == '0);
            par_d   = ^res;
            if (cf_load) cf_d = res_co | res_br;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            co_q        <= 1'b0;
            br_q        <= 1'b0;
            zero_q      <= 1'b1;
            par_q       <= 1'b0;
            inv_q       <= 1'b0;
            cf_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q      <= '0;
            mcand_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            co_q        <= co_d;
            br_q        <= br_d;
            zero_q      <= zero_d;
            par_q       <= par_d;
            inv_q       <= inv_d;
            cf_q        <= cf_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
`ifdef ALU_SEQ_MUL_EN
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.y          = y_q;
    assign bus.carry_out  = co_q;
    assign bus.borrow     = br_q;
    assign bus.zero       = zero_q;
    assign bus.parity     = par_q;
    assign bus.invalid_op = inv_q;
    assign bus.carry_flag = cf_q;
endmodule
